pipelined_addsub_cla: RTL and testbench
=======================================

// Module: pipelined_addsub_cla
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor: next generation of the 20-bit CLA add/sub.
//   Splits the WIDTH-bit operation into STAGES = WIDTH/CHUNK carry-lookahead chunks, one chunk per stage.
//   Carry is registered between stages; operands are skewed/deskewed through the pipe.
//   Valid/ready handshake on both sides for the datapath/ALU layer; optional signed saturation.
// PARAMETERS
//   WIDTH     20  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK     5   bits resolved per pipeline stage (combinational CLA group)
//   SATURATE  0   1 = clamp Sum to signed max/min on overflow; 0 = wraparound
// PORTS
//   CLK        in   1      rising-edge clock
//   RST        in   1      asynchronous, active-high reset
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   SUB        in   1      0: A+B, 1: A-B; sampled with A/B
//   IN_VALID   in   1      A/B/SUB valid this cycle
//   IN_READY   out  1      pipe can accept this cycle
//   Sum        out  WIDTH  result (wrapped or saturated)
//   Carry      out  1      carry out of MSB (for SUB: 1 = no borrow)
//   OVF        out  1      signed overflow (pre-saturation)
//   OUT_VALID  out  1      Sum/Carry/OVF valid
//   OUT_READY  in   1      downstream accepts result
// BEHAVIOUR
//   - Reset (async, RST=1): all stage valid bits, Sum, Carry, OVF, OUT_VALID = 0; IN_READY = 1 after release.
//     Reset mid-operation discards every in-flight transaction; no partial result is ever emitted.
//   - Arithmetic: D = B ^ {WIDTH{SUB}}, carry-in of chunk 0 = SUB; result = A + D + SUB mod 2^WIDTH.
//     Carry = carry out of bit WIDTH-1. OVF = carry into MSB XOR carry out of MSB.
//   - SATURATE=1 and OVF=1: Sum = 0 1..1 if A[MSB]=0, else 1 0..0; Carry and OVF unchanged.
//   - Stage s (0..STAGES-1) computes chunk s from registered carry of stage s-1 and registers
//     sum chunk s, carry out, plus remaining unused A/D chunks and lower computed Sum chunks.
//   - Pipeline enable EN = !OUT_VALID || OUT_READY (global stall). IN_READY = EN.
//     When EN=0 all stage registers and valid bits hold; inputs not accepted.
//   - Accept when IN_VALID && IN_READY on a rising edge. Latency = STAGES cycles: result is on the
//     outputs with OUT_VALID=1 after STAGES rising edges, counting the accepting edge (20/5: 4).
//   - Throughput 1 op/cycle when OUT_READY=1. Bubbles (IN_VALID=0) propagate as valid=0 slots;
//     bubbles are not compressed.
//   - Output holds Sum/Carry/OVF stable while OUT_VALID && !OUT_READY.
//   - Ordering strictly in-order; no reordering, no drops, no duplicates.
//   - Simultaneous accept and emit in one cycle is legal and required at full rate.
//   - Sum/Carry/OVF hold last value when OUT_VALID=0 (don't-care for checking).
// TESTING
//   1. WIDTH=20: A=0x7FFFF, B=0x00001, SUB=0 -> after 4 cycles Sum=0x80000, Carry=0, OVF=1;
//      SATURATE=1 -> Sum=0x7FFFF, OVF=1.
//   2. A=5, B=3, SUB=1 -> Sum=0x00002, Carry=1, OVF=0; A=3, B=5, SUB=1 -> Sum=0xFFFFE, Carry=0, OVF=0.
//   3. Back-to-back stream of 100 random ops with OUT_READY=1 -> one result per cycle, in order,
//      each matching the reference model (A+B or A-B mod 2^20, carry, overflow).
//   4. OUT_READY low for 6 cycles with pipe full -> IN_READY=0, outputs stable;
//      resume -> no loss or duplication.
//   5. Assert RST with 3 ops in flight -> OUT_VALID=0 immediately; none of those ops ever emitted.
//   6. Carry-chain across chunks: A=0xFFFFF, B=0x00001, SUB=0 -> Sum=0, Carry=1, OVF=0;
//      repeat with WIDTH=32, CHUNK=8 -> latency 4, same pass rules.

Source files
------------

// File: rtl/pipelined_addsub_cla.sv
// Pipelined two's-complement adder/subtractor: one carry-lookahead chunk per stage,
// carry registered between stages, optional signed saturation on the last stage.
module pipelined_addsub_cla #(
    parameter int WIDTH    = 20,
    parameter int CHUNK    = 5,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready. The whole pipe advances together, so IN_READY is the stall enable.
    logic en;
    assign en       = !OUT_VALID || OUT_READY;
    assign IN_READY = en;

    // Stage registers: valid, operand A, operand D (B possibly inverted), partial sum, carry.
    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] d_q;
    logic [STAGES-1:0][WIDTH-1:0] sum_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0]            ovf_q;

    // Values entering each stage and the values it will register.
    logic [STAGES-1:0]            v_src;
    logic [STAGES-1:0][WIDTH-1:0] a_src;
    logic [STAGES-1:0][WIDTH-1:0] d_src;
    logic [STAGES-1:0][WIDTH-1:0] s_src;
    logic [STAGES-1:0]            c_src;
    logic [STAGES-1:0][CHUNK+1:0] res;
    logic [STAGES-1:0][WIDTH-1:0] sum_nx;
    logic [STAGES-1:0]            carry_nx;
    logic [STAGES-1:0]            ovf_nx;

    // Returns {carry out, carry into top bit, chunk sum}; carries are flattened lookahead terms.
    function automatic logic [CHUNK+1:0] cla_chunk(input logic [CHUNK-1:0] a,
                                                   input logic [CHUNK-1:0] d,
                                                   input logic             cin);
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             acc;
        logic             prod;
        g    = a & d;
        p    = a ^ d;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i+1] = acc | (cin & prod);
        end
        return {c[CHUNK], c[CHUNK-1], p ^ c[CHUNK-1:0]};
    endfunction

    always_comb begin
        v_src    = '0;
        a_src    = '0;
        d_src    = '0;
        s_src    = '0;
        c_src    = '0;
        res      = '0;
        sum_nx   = '0;
        carry_nx = '0;
        ovf_nx   = '0;

        v_src[0] = IN_VALID;
        a_src[0] = A;
        d_src[0] = B ^ {WIDTH{SUB}};
        c_src[0] = SUB;
        for (int s = 1; s < STAGES; s++) begin
            v_src[s] = v_q[s-1];
            a_src[s] = a_q[s-1];
            d_src[s] = d_q[s-1];
            s_src[s] = sum_q[s-1];
            c_src[s] = c_q[s-1];
        end

        for (int s = 0; s < STAGES; s++) begin
            res[s]                      = cla_chunk(a_src[s][s*CHUNK +: CHUNK],
                                                    d_src[s][s*CHUNK +: CHUNK], c_src[s]);
            sum_nx[s]                   = s_src[s];
            sum_nx[s][s*CHUNK +: CHUNK] = res[s][CHUNK-1:0];
            carry_nx[s]                 = res[s][CHUNK+1];
            ovf_nx[s]                   = res[s][CHUNK+1] ^ res[s][CHUNK];
        end

        // Clamp direction follows A's sign: overflow only happens when A and D agree in sign.
        if (SATURATE != 0 && ovf_nx[STAGES-1]) begin
            sum_nx[STAGES-1] = a_src[STAGES-1][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q   <= '0;
            a_q   <= '0;
            d_q   <= '0;
            sum_q <= '0;
            c_q   <= '0;
            ovf_q <= '0;
        end else if (en) begin
            v_q <= v_src;
            for (int s = 0; s < STAGES; s++) begin
                if (v_src[s]) begin
                    a_q[s]   <= a_src[s];
                    d_q[s]   <= d_src[s];
                    sum_q[s] <= sum_nx[s];
                    c_q[s]   <= carry_nx[s];
                    ovf_q[s] <= ovf_nx[s];
                end
            end
        end
    end

    assign Sum       = sum_q[STAGES-1];
    assign Carry     = c_q[STAGES-1];
    assign OVF       = ovf_q[STAGES-1];
    assign OUT_VALID = v_q[STAGES-1];

    // Operand chunks already consumed and the early-stage overflow bits are not read downstream.
    logic unused_ok;
    assign unused_ok = ^{a_q, d_q, ovf_q};

endmodule

// File: tb/tb_pipelined_addsub_cla.sv
// Bench for pipelined_addsub_cla: 20/5 wrap and saturate instances side by side,
// plus a 32/8 instance for the wide carry-chain and latency checks.
module tb_pipelined_addsub_cla;

    logic        clk;
    logic        rst;
    logic [19:0] a;
    logic [19:0] b;
    logic        sub;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_s;
    logic [19:0] sum;
    logic [19:0] sum_s;
    logic        carry;
    logic        carry_s;
    logic        ovf;
    logic        ovf_s;
    logic        out_valid;
    logic        out_valid_s;
    logic        out_ready;

    logic [31:0] a32;
    logic [31:0] b32;
    logic        sub32;
    logic        iv32;
    logic        ir32;
    logic [31:0] sum32;
    logic        c32;
    logic        ovf32;
    logic        ov32;
    logic        or32;

    pipelined_addsub_cla #(.WIDTH(20), .CHUNK(5), .SATURATE(0)) dut (
        .CLK(clk), .RST(rst), .A(a), .B(b), .SUB(sub), .IN_VALID(in_valid),
        .IN_READY(in_ready), .Sum(sum), .Carry(carry), .OVF(ovf),
        .OUT_VALID(out_valid), .OUT_READY(out_ready)
    );

    pipelined_addsub_cla #(.WIDTH(20), .CHUNK(5), .SATURATE(1)) dut_sat (
        .CLK(clk), .RST(rst), .A(a), .B(b), .SUB(sub), .IN_VALID(in_valid),
        .IN_READY(in_ready_s), .Sum(sum_s), .Carry(carry_s), .OVF(ovf_s),
        .OUT_VALID(out_valid_s), .OUT_READY(out_ready)
    );

    pipelined_addsub_cla #(.WIDTH(32), .CHUNK(8), .SATURATE(0)) dut32 (
        .CLK(clk), .RST(rst), .A(a32), .B(b32), .SUB(sub32), .IN_VALID(iv32),
        .IN_READY(ir32), .Sum(sum32), .Carry(c32), .OVF(ovf32),
        .OUT_VALID(ov32), .OUT_READY(or32)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Expected record layout: {saturated sum[41:22], wrapped sum[21:2], carry[1], ovf[0]}
    int          checks = 0;
    int          errors = 0;
    logic [41:0] exp_q[$];
    logic [41:0] cur_exp;
    logic [41:0] e;
    int          cyc = 0;
    int          emit_n = 0;
    int          emit_first = -1;
    int          emit_last = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [41:0] model(input logic [19:0] ma, input logic [19:0] mb,
                                          input logic ms);
        logic [19:0] d;
        logic [20:0] full;
        logic [19:0] s;
        logic        ov;
        logic [19:0] sat;
        d    = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, d} + {20'd0, ms};
        s    = full[19:0];
        ov   = (ma[19] == d[19]) && (s[19] != ma[19]);
        sat  = ov ? (ma[19] ? 20'h80000 : 20'h7FFFF) : s;
        return {sat, s, full[20], ov};
    endfunction

    // Samples on the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("output_while_idle", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({sum_s, sum, carry, ovf}), 64'(e));
                    check("sat_flags", 64'({carry_s, ovf_s, out_valid_s}),
                          64'({e[1], e[0], 1'b1}));
                    emit_n++;
                    if (emit_first < 0) emit_first = cyc;
                    emit_last = cyc;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic [19:0] ta, input logic [19:0] tb_, input logic ts,
                        input logic [41:0] te);
        logic acc;
        int   n;
        a        = ta;
        b        = tb_;
        sub      = ts;
        cur_exp  = te;
        in_valid = 1'b1;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            n++;
        end
        if (!acc) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send32(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                          input logic [31:0] es, input logic ec, input logic ev);
        int lat;
        a32   = ta;
        b32   = tb_;
        sub32 = ts;
        iv32  = 1'b1;
        check("in_ready32", 64'(ir32), 64'd1);
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        lat  = 1;
        while (!ov32 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency32", 64'(lat), 64'd4);
        check("result32", 64'({sum32, c32, ovf32}), 64'({es, ec, ev}));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [19:0] a;
        logic [19:0] b;
        logic        sub;
        logic [19:0] sum;
        logic        c;
        logic        v;
        logic [19:0] sat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [19:0] ra;
        logic [19:0] rb;
        logic        rs;
        logic [63:0] held;
        int          lat;
        int          seen;

        tbl[0] = '{20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1, 20'h7FFFF};
        tbl[1] = '{20'h00005, 20'h00003, 1'b1, 20'h00002, 1'b1, 1'b0, 20'h00002};
        tbl[2] = '{20'h00003, 20'h00005, 1'b1, 20'hFFFFE, 1'b0, 1'b0, 20'hFFFFE};
        tbl[3] = '{20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00000};
        tbl[4] = '{20'h80000, 20'h00001, 1'b1, 20'h7FFFF, 1'b1, 1'b1, 20'h80000};
        tbl[5] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h80000};
        tbl[6] = '{20'h00000, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0, 20'h00000};
        tbl[7] = '{20'h12345, 20'h54321, 1'b0, 20'h66666, 1'b0, 1'b0, 20'h66666};
        tbl[8] = '{20'h00000, 20'h00001, 1'b1, 20'hFFFFF, 1'b0, 1'b0, 20'hFFFFF};
        tbl[9] = '{20'h7FFFF, 20'hFFFFF, 1'b1, 20'h80000, 1'b0, 1'b1, 20'h7FFFF};

        rst       = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;
        a32       = '0;
        b32       = '0;
        sub32     = 1'b0;
        iv32      = 1'b0;
        or32      = 1'b1;

        // Reset state
        #1;
        check("reset_out_valid", 64'({out_valid, out_valid_s, ov32}), 64'd0);
        check("reset_outputs", 64'({sum, carry, ovf, sum_s}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 64'({in_ready, in_ready_s, ir32}), 64'h7);

        // Latency of a single op
        send(20'h00005, 20'h00003, 1'b1, model(20'h00005, 20'h00003, 1'b1));
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency20", 64'(lat), 64'd4);
        drain();

        // Directed table, back to back
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sub,
                 {tbl[i].sat, tbl[i].sum, tbl[i].c, tbl[i].v});
        end
        drain();

        // 100 random ops at full rate
        emit_n     = 0;
        emit_first = -1;
        emit_last  = -1;
        for (int i = 0; i < 100; i++) begin
            ra = 20'($urandom_range(32'hFFFFF, 0));
            rb = 20'($urandom_range(32'hFFFFF, 0));
            rs = 1'($urandom_range(1, 0));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();
        check("stream_count", 64'(emit_n), 64'd100);
        check("stream_one_per_cycle", 64'(emit_last - emit_first), 64'd99);

        // Stall with pipe full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = 20'($urandom_range(32'hFFFFF, 0));
            rb = 20'($urandom_range(32'hFFFFF, 0));
            send(ra, rb, 1'b0, model(ra, rb, 1'b0));
        end
        ra       = 20'h7FFFF;
        rb       = 20'h00001;
        a        = ra;
        b        = rb;
        sub      = 1'b0;
        cur_exp  = model(ra, rb, 1'b0);
        in_valid = 1'b1;
        held     = 64'({sum, carry, ovf, sum_s});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'({in_ready, in_ready_s}), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'({sum, carry, ovf, sum_s}), held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(ra, rb, 1'b0, model(ra, rb, 1'b0));
        send(20'h00003, 20'h00005, 1'b1, model(20'h00003, 20'h00005, 1'b1));
        drain();

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            ra = 20'($urandom_range(32'hFFFFF, 0));
            rb = 20'($urandom_range(32'hFFFFF, 0));
            send(ra, rb, 1'b1, model(ra, rb, 1'b1));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("preflush_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("flush_out_valid", 64'({out_valid, out_valid_s}), 64'd0);
        check("flush_outputs", 64'({sum, carry, ovf}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_emit", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        send(20'h00005, 20'h00003, 1'b1, model(20'h00005, 20'h00003, 1'b1));
        drain();

        // Wide instance: carry across every chunk, overflow at the top
        idle(1);
        send32(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send32(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send32(32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);

        idle(2);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
